// File: rtl/truth_table_sweeper_if.sv
// Handshake bundle between the sweeper and its controller / gate under test.
// Purely combinational; no backpressure: the sweeper owns gate_in, and the controller observes the status signals.
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic       use_default;
    logic [7:0] exp_tt;
    logic [2:0] gate_in;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] meas_tt;
    logic [7:0] err_mask;

    modport slave (
        input  start, abort, use_default, exp_tt, gate_out,
        output gate_in, busy, done, pass, meas_tt, err_mask
    );

    modport master (
        output start, abort, use_default, exp_tt, gate_out,
        input  gate_in, busy, done, pass, meas_tt, err_mask
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all 8 vectors, taking SETTLE_CYCLES+1 cycles per vector, and compares the result with an expected table.
// The sweep completes 8*(SETTLE_CYCLES+1) cycles after start; there is no backpressure: start is ignored while busy, and abort ends a sweep.
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] DEFAULT_TT    = 8'hB6
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_k;
    logic [7:0] r_cnt;
    logic [7:0] r_exp;
    logic [7:0] r_meas;
    logic [7:0] r_err_mask;
    logic       r_pass;
    logic [1:0] r_sync;
    logic [7:0] w_meas_nxt;
    logic       w_start_ok;

    assign w_start_ok = bus.start && !bus.abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.gate_out};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_meas_nxt  = r_meas;
        w_meas_nxt[3'd7 - r_k] = r_sync[1];
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (bus.abort)          w_state_nxt = S_IDLE;
                else if (r_cnt == 8'd0) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (bus.abort)          w_state_nxt = S_IDLE;
                else if (r_k == 3'd7)   w_state_nxt = S_DONE;
                else                    w_state_nxt = S_SETTLE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results for the final vector are folded into err_mask/pass on the same edge that enters DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k        <= 3'd0;
            r_cnt      <= 8'd0;
            r_exp      <= 8'd0;
            r_meas     <= 8'd0;
            r_err_mask <= 8'd0;
            r_pass     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_exp      <= bus.use_default ? DEFAULT_TT : bus.exp_tt;
                        r_meas     <= 8'd0;
                        r_err_mask <= 8'd0;
                        r_pass     <= 1'b0;
                        r_k        <= 3'd0;
                        r_cnt      <= CNT_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort)          r_k   <= 3'd0;
                    else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                end
                S_SAMPLE: begin
                    if (bus.abort) begin
                        r_k <= 3'd0;
                    end else begin
                        r_meas <= w_meas_nxt;
                        if (r_k != 3'd7) begin
                            r_k   <= r_k + 3'd1;
                            r_cnt <= CNT_LOAD;
                        end else begin
                            r_err_mask <= w_meas_nxt ^ r_exp;
                            r_pass     <= (w_meas_nxt == r_exp);
                        end
                    end
                end
                S_DONE: begin
                    r_k <= 3'd0;
                end
                default: r_k <= 3'd0;
            endcase
        end
    end

    assign bus.gate_in  = (r_state == S_SETTLE || r_state == S_SAMPLE) ? r_k : 3'd0;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.pass     = r_pass;
    assign bus.meas_tt  = r_meas;
    assign bus.err_mask = r_err_mask;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles each input vector is held before sampling; legal range 2..255.
REQ-002 Parameter DEFAULT_TT, default 8'hB6: expected truth table used when use_default is high at start.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a sweep; accepted only in IDLE.
REQ-006 abort  input  1  terminate a sweep in progress.
REQ-007 use_default  input  1  at start: 1 = expect DEFAULT_TT, 0 = expect exp_tt.
REQ-008 exp_tt  input  8  expected truth table; bit 7-k is the expected output for input combination k.
REQ-009 gate_in  output  3  drives {in1,in2,in3} of the 3-input gate under test.
REQ-010 gate_out  input  1  gate output; may be asynchronous to clk.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 pass  output  1  meas_tt == latched expected table; valid from done until next accepted start.
REQ-014 meas_tt  output  8  measured table, bit 7-k = sampled output for combination k.
REQ-015 err_mask  output  8  meas_tt XOR latched expected table.

Function
REQ-016 States SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-017 gate_out SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-018 IDLE + start (abort low): latch expected table (DEFAULT_TT or exp_tt), clear meas_tt, err_mask and pass, set index k=0, gate_in=0, load settle counter, go SETTLE.
REQ-019 SETTLE: gate_in = k, held for exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-020 SAMPLE (one cycle): write synchronized gate_out into meas_tt[7-k]; if k<7, set k=k+1, drive gate_in=k+1, reload counter, go SETTLE; if k=7, go DONE.
REQ-021 Each vector SHALL take SETTLE_CYCLES+1 cycles; done SHALL be high in the cycle beginning 8*(SETTLE_CYCLES+1) edges after the start-accepting edge (40 for the default).
REQ-022 DONE (one cycle): done=1; err_mask and pass reflect the final meas_tt; gate_in returns to 0; next state IDLE.
REQ-023 err_mask and pass SHALL be updated combinationally or registered such that both are correct while done=1 and remain stable in IDLE.
REQ-024 gate_in SHALL be 0 in IDLE and DONE.
REQ-025 start while busy SHALL be ignored, with no effect on k, counter or results.
REQ-026 abort in SETTLE or SAMPLE: next state IDLE, gate_in=0, no done pulse, pass=0, meas_tt keeps only the bits already sampled.
REQ-027 abort and start together in IDLE: abort wins; stay IDLE.
REQ-028 abort in DONE: ignored; done still pulses.
REQ-029 k SHALL never wrap; the sweep ends after k=7.

Reset
REQ-030 reset high SHALL immediately force IDLE, k=0, gate_in=0, busy=0, done=0, pass=0, meas_tt=0, err_mask=0, expected table=0, and clear the synchronizer.
REQ-031 reset asserted mid-sweep SHALL abandon the sweep with no done pulse; the first start after deassertion begins a fresh sweep at k=0.

Verification
REQ-032 Gate model = 0xB6 function, use_default=1, start -> gate_in steps 0..7; done at edge 40; meas_tt=8'hB6, err_mask=0, pass=1.
REQ-033 Same gate, use_default=0, exp_tt=8'hB7 -> meas_tt=8'hB6, err_mask=8'h01, pass=0.
REQ-034 gate_out stuck at 1, exp_tt=8'hB6 -> meas_tt=8'hFF, err_mask=8'h49, pass=0.
REQ-035 abort during SETTLE of k=3 -> IDLE next cycle, gate_in=0, no done pulse, meas_tt[7:5]=3'b101, pass=0.
REQ-036 start pulsed at k=2 while busy, then reset asserted at k=5 -> first start ignored; on reset all outputs 0, no done; a new start completes a full 40-cycle sweep.
REQ-037 start and abort high together in IDLE -> busy stays 0 and gate_in stays 0.
